// File: rtl/apb_bridge_requester_if.sv
// Request/response port plus APB bus bundle for the APB requester bridge.
// The master modport is the bridge side; the slave modport is the requester/fabric side.
interface apb_bridge_requester_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int DEC_NUMBER = 16
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_write_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;

  logic                  rsp_valid_o;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;

  logic [ADDR_WIDTH-1:0] paddr;
  logic                  penable;
  logic [DEC_NUMBER-1:0] pselx;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;

  modport master (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, prdata,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output paddr, penable, pselx, pwrite, pwdata
  );

  modport slave (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, prdata,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  paddr, penable, pselx, pwrite, pwdata
  );
endinterface

// File: rtl/apb_bridge_requester.sv
// APB2 initiator: valid/ready request in, SETUP + one-cycle ACCESS out, registered response pulse.
// Address decodes to a one-hot pselx slot; out-of-range addresses run the bus phases unselected.
module apb_bridge_requester #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int DEC_NUMBER = 16,
  parameter int SLOT_SHIFT = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  apb_bridge_requester_if.master bus
);
  localparam int SEL_WIDTH = $clog2(DEC_NUMBER);
  localparam int HI_LSB    = SLOT_SHIFT + SEL_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state;
  logic   err_p1;
  logic   accept;

  // Any address bit above the slot field, or a slot index past the last slave, is a decode error.
  function automatic logic decode_err(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] hi;
    logic [SEL_WIDTH-1:0]  slot;
    hi   = addr >> HI_LSB;
    slot = addr[SLOT_SHIFT +: SEL_WIDTH];
    return (hi != '0) || (int'(slot) >= DEC_NUMBER);
  endfunction

  function automatic logic [DEC_NUMBER-1:0] decode_sel(input logic [ADDR_WIDTH-1:0] addr);
    if (decode_err(addr)) return '0;
    return DEC_NUMBER'(1) << addr[SLOT_SHIFT +: SEL_WIDTH];
  endfunction

  assign bus.req_ready_o = (state != SETUP);
  assign accept          = bus.req_valid_i && bus.req_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= IDLE;
      err_p1          <= 1'b0;
      bus.paddr       <= '0;
      bus.penable     <= 1'b0;
      bus.pselx       <= '0;
      bus.pwrite      <= 1'b0;
      bus.pwdata      <= '0;
      bus.rsp_valid_o <= 1'b0;
      bus.rsp_rdata_o <= '0;
      bus.rsp_err_o   <= 1'b0;
    end else begin
      bus.rsp_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          bus.penable <= 1'b0;
          bus.pselx   <= '0;
        end
        SETUP: begin
          bus.penable <= 1'b1;
          state       <= ACCESS;
        end
        ACCESS: begin
          // Transfer completes here; prdata is only meaningful for an in-range read.
          bus.rsp_valid_o <= 1'b1;
          bus.rsp_err_o   <= err_p1;
          bus.rsp_rdata_o <= (!bus.pwrite && !err_p1) ? bus.prdata : '0;
          bus.penable     <= 1'b0;
          bus.pselx       <= '0;
          state           <= IDLE;
        end
        default: begin
          bus.penable <= 1'b0;
          bus.pselx   <= '0;
          state       <= IDLE;
        end
      endcase
      // A handshake in IDLE or ACCESS launches the next SETUP, overriding the ACCESS wind-down.
      if (accept) begin
        bus.paddr   <= bus.req_addr_i;
        bus.pwrite  <= bus.req_write_i;
        bus.pwdata  <= bus.req_wdata_i;
        bus.pselx   <= decode_sel(bus.req_addr_i);
        bus.penable <= 1'b0;
        err_p1      <= decode_err(bus.req_addr_i);
        state       <= SETUP;
      end
    end
  end
endmodule

// File: tb/tb_apb_bridge_requester.sv
// Bench for apb_bridge_requester: directed scenarios plus randomized traffic against a
// cycle-timeline reference model (accept at N -> SETUP N+1, ACCESS N+2, response N+3).
`timescale 1ns/1ps
module tb_apb_bridge_requester;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int DN = 16;
  localparam int SS = 12;
  localparam int NC = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_bridge_requester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEC_NUMBER(DN)) bus ();

  apb_bridge_requester #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEC_NUMBER(DN), .SLOT_SHIFT(SS)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Expected per-cycle bus activity, filled ahead of time when a request is accepted.
  bit            e_setup [NC];
  bit            e_en    [NC];
  logic [DN-1:0] e_sel   [NC];
  bit            e_rv    [NC];
  bit            e_err   [NC];
  logic [DW-1:0] e_rd    [NC];
  bit            upd     [NC];
  logic [AW-1:0] u_addr  [NC];
  bit            u_wr    [NC];
  logic [DW-1:0] u_wd    [NC];
  bit            acc     [NC];
  bit            acc_rd  [NC];
  bit            acc_err [NC];

  logic [AW-1:0] m_addr;
  bit            m_wr;
  logic [DW-1:0] m_wd;
  logic [DW-1:0] m_rd;
  bit            m_err;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic clear_model(input int from);
    for (int k = from; k < NC; k++) begin
      e_setup[k] = 0; e_en[k] = 0; e_sel[k] = '0; e_rv[k] = 0; e_err[k] = 0; e_rd[k] = '0;
      upd[k] = 0; u_addr[k] = '0; u_wr[k] = 0; u_wd[k] = '0;
      acc[k] = 0; acc_rd[k] = 0; acc_err[k] = 0;
    end
    m_addr = '0; m_wr = 0; m_wd = '0; m_rd = '0; m_err = 0;
  endtask

  task automatic check_cycle();
    if (upd[cyc]) begin
      m_addr = u_addr[cyc]; m_wr = u_wr[cyc]; m_wd = u_wd[cyc];
    end
    if (e_rv[cyc]) begin
      m_rd = e_rd[cyc]; m_err = e_err[cyc];
    end
    chk("ready",     DW'(bus.req_ready_o), DW'(!e_setup[cyc]));
    chk("pselx",     DW'(bus.pselx),       DW'(e_sel[cyc]));
    chk("penable",   DW'(bus.penable),     DW'(e_en[cyc]));
    chk("paddr",     DW'(bus.paddr),       DW'(m_addr));
    chk("pwrite",    DW'(bus.pwrite),      DW'(m_wr));
    chk("pwdata",    bus.pwdata,           m_wd);
    chk("rsp_valid", DW'(bus.rsp_valid_o), DW'(e_rv[cyc]));
    chk("rsp_rdata", bus.rsp_rdata_o,      m_rd);
    chk("rsp_err",   DW'(bus.rsp_err_o),   DW'(m_err));
  endtask

  task automatic model_cycle(input bit v, input bit w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [DW-1:0] p);
    logic [AW-1:0] region;
    logic [DN-1:0] sel;
    bit            err;
    if (v && !e_setup[cyc]) begin
      region = a / (AW'(1) << SS);
      err    = (region >= AW'(DN));
      sel    = '0;
      if (!err) sel[region] = 1'b1;
      upd[cyc+1] = 1; u_addr[cyc+1] = a; u_wr[cyc+1] = w; u_wd[cyc+1] = d;
      e_setup[cyc+1] = 1; e_sel[cyc+1] = sel;
      e_sel[cyc+2] = sel; e_en[cyc+2] = 1;
      acc[cyc+2] = 1; acc_rd[cyc+2] = !w && !err; acc_err[cyc+2] = err;
    end
    if (acc[cyc]) begin
      e_rv[cyc+1]  = 1;
      e_err[cyc+1] = acc_err[cyc];
      e_rd[cyc+1]  = acc_rd[cyc] ? p : '0;
    end
  endtask

  // One cycle: check outputs of the current cycle, drive its inputs, advance to the next mid-cycle.
  task automatic step(input bit v, input bit w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [DW-1:0] p);
    check_cycle();
    bus.req_valid_i = v;
    bus.req_write_i = w;
    bus.req_addr_i  = a;
    bus.req_wdata_i = d;
    bus.prdata      = p;
    model_cycle(v, w, a, d, p);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic idle();
    step(0, 0, '0, '0, rnd64());
  endtask

  logic [5:0]    pen_pat;
  logic [AW-1:0] ra;
  logic [DW-1:0] pv;

  initial begin
    bus.req_valid_i = 0; bus.req_write_i = 0; bus.req_addr_i = '0;
    bus.req_wdata_i = '0; bus.prdata = '0;
    clear_model(0);
    #1;
    chk("rst_paddr",   DW'(bus.paddr),       '0);
    chk("rst_penable", DW'(bus.penable),     '0);
    chk("rst_pselx",   DW'(bus.pselx),       '0);
    chk("rst_pwrite",  DW'(bus.pwrite),      '0);
    chk("rst_pwdata",  bus.pwdata,           '0);
    chk("rst_rvalid",  DW'(bus.rsp_valid_o), '0);
    chk("rst_rdata",   bus.rsp_rdata_o,      '0);
    chk("rst_rerr",    DW'(bus.rsp_err_o),   '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    cyc = 0;

    // Single write
    step(1, 1, 32'h0000_3010, 64'hDEAD_BEEF_0000_0001, rnd64());
    chk("wr_pselx",    DW'(bus.pselx),       DW'(16'h0008));
    chk("wr_penable0", DW'(bus.penable),     DW'(1'b0));
    chk("wr_pwrite",   DW'(bus.pwrite),      DW'(1'b1));
    chk("wr_paddr",    DW'(bus.paddr),       DW'(32'h3010));
    chk("wr_ready0",   DW'(bus.req_ready_o), DW'(1'b0));
    idle();
    chk("wr_penable1", DW'(bus.penable),     DW'(1'b1));
    idle();
    chk("wr_rvalid",   DW'(bus.rsp_valid_o), DW'(1'b1));
    chk("wr_rerr",     DW'(bus.rsp_err_o),   DW'(1'b0));
    chk("wr_rdata",    bus.rsp_rdata_o,      '0);
    idle();

    // Single read
    step(1, 0, 32'h0000_F000, rnd64(), rnd64());
    chk("rd_pselx", DW'(bus.pselx), DW'(16'h8000));
    idle();
    step(0, 0, '0, '0, 64'h1234_5678_9ABC_DEF0);
    chk("rd_rvalid", DW'(bus.rsp_valid_o), DW'(1'b1));
    chk("rd_rdata",  bus.rsp_rdata_o,      64'h1234_5678_9ABC_DEF0);
    idle();
    chk("rd_hold",   bus.rsp_rdata_o,      64'h1234_5678_9ABC_DEF0);

    // Back-to-back: valid held for five cycles yields three accepts
    pen_pat = '0;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) step(1, i[0], AW'(32'h1000 * (i + 1)), rnd64(), rnd64());
      else       idle();
      pen_pat = {pen_pat[4:0], bus.penable};
    end
    chk("b2b_penable", DW'(pen_pat), DW'(6'b010101));
    repeat (2) idle();

    // Decode error then a normal read
    step(1, 0, 32'h0001_0000, rnd64(), rnd64());
    chk("err_pselx_setup", DW'(bus.pselx), '0);
    idle();
    chk("err_pselx_access", DW'(bus.pselx),   '0);
    chk("err_penable",      DW'(bus.penable), DW'(1'b1));
    idle();
    chk("err_rerr",  DW'(bus.rsp_err_o), DW'(1'b1));
    chk("err_rdata", bus.rsp_rdata_o,    '0);
    step(1, 0, 32'h0000_2008, rnd64(), rnd64());
    idle();
    step(0, 0, '0, '0, 64'hCAFE_F00D_0000_0042);
    chk("post_err_rdata", bus.rsp_rdata_o,    64'hCAFE_F00D_0000_0042);
    chk("post_err_rerr",  DW'(bus.rsp_err_o), DW'(1'b0));
    idle();

    // Reset in the ACCESS cycle drops the transfer
    step(1, 0, 32'h0000_5000, rnd64(), rnd64());
    idle();
    chk("mid_penable_before", DW'(bus.penable), DW'(1'b1));
    rst = 1;
    #1;
    chk("mid_penable", DW'(bus.penable),     '0);
    chk("mid_pselx",   DW'(bus.pselx),       '0);
    chk("mid_rvalid",  DW'(bus.rsp_valid_o), '0);
    clear_model(cyc);
    @(posedge clk);
    cyc++;
    #1;
    chk("mid_no_rsp", DW'(bus.rsp_valid_o), '0);
    @(negedge clk);
    rst = 0;
    step(1, 0, 32'h0000_7ABC, rnd64(), rnd64());
    idle();
    step(0, 0, '0, '0, 64'h0BAD_C0DE_1111_2222);
    chk("after_rst_rvalid", DW'(bus.rsp_valid_o), DW'(1'b1));
    chk("after_rst_rdata",  bus.rsp_rdata_o,       64'h0BAD_C0DE_1111_2222);

    // Randomized traffic
    for (int i = 0; i < 700; i++) begin
      case ($urandom_range(0, 7))
        0:       ra = $urandom;
        1:       ra = 32'h0001_0000;
        2:       ra = 32'h0000_FFFF;
        default: ra = AW'($urandom_range(0, 65535));
      endcase
      pv = rnd64();
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), ra, rnd64(), pv);
    end
    repeat (4) idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
